// File: rtl/regf_mem_master_pkg.sv
// Shared types and helpers for the regf mem-bus initiator.
package regf_mem_master_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpRmw   = 2'd2,
    OpPoll  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StPgap,
    StRsp
  } state_e;

  // Widest data bus the merge helper supports; callers zero-extend and truncate.
  localparam int unsigned MaxDw = 64;

  function automatic logic [MaxDw-1:0] rmw_merge(input logic [MaxDw-1:0] old_val,
                                                 input logic [MaxDw-1:0] new_val,
                                                 input logic [MaxDw-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/regf_mem_master_if.sv
// Register-file mem bus: single-cycle access with same-cycle read data and decode error.
interface regf_mem_master_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 32
) ();

  logic          ena;
  logic [AW-1:0] addr;
  logic          wena;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output ena, addr, wena, wdata,
    input  rdata, err
  );

  modport slave (
    input  ena, addr, wena, wdata,
    output rdata, err
  );

endinterface

// File: rtl/regf_mem_master.sv
// Command-to-mem-bus initiator for regf blocks: READ, WRITE, RMW and POLL.
// POLL retry logic is built only when REGF_MEM_MASTER_POLL_EN is defined.
module regf_mem_master
  import regf_mem_master_pkg::*;
#(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 32,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_an_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [AW-1:0]        cmd_addr_i,
  input  logic [DW-1:0]        cmd_wdata_i,
  input  logic [DW-1:0]        cmd_mask_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  regf_mem_master_if.master    mem,
  output logic                 busy_o
);

  state_e        state_q;
  op_e           op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mask_q;

  logic          mem_ena_q;
  logic          mem_wena_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_err_q;

`ifdef REGF_MEM_MASTER_POLL_EN
  localparam int unsigned CntW = $clog2(POLL_MAX + 1);
  logic [CntW-1:0] poll_cnt_q;
  logic            rsp_timeout_q;
  logic            poll_hit;

  assign poll_hit      = ((mem.rdata ^ wdata_q) & mask_q) == '0;
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      mem_ena_q   <= 1'b0;
      mem_wena_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef REGF_MEM_MASTER_POLL_EN
      poll_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q        <= op_e'(cmd_op_i);
            addr_q      <= cmd_addr_i;
            wdata_q     <= cmd_wdata_i;
            mask_q      <= cmd_mask_i;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef REGF_MEM_MASTER_POLL_EN
            poll_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
            case (op_e'(cmd_op_i))
              OpWrite: begin
                state_q     <= StWr;
                mem_ena_q   <= 1'b1;
                mem_wena_q  <= 1'b1;
                mem_addr_q  <= cmd_addr_i;
                mem_wdata_q <= cmd_wdata_i;
              end
`ifndef REGF_MEM_MASTER_POLL_EN
              // Unsupported in this build: answer with an error, never touch the bus.
              OpPoll: begin
                state_q     <= StRsp;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
`endif
              default: begin
                state_q     <= StRd;
                mem_ena_q   <= 1'b1;
                mem_wena_q  <= 1'b0;
                mem_addr_q  <= cmd_addr_i;
                mem_wdata_q <= '0;
              end
            endcase
          end
        end

        StRd: begin
          mem_ena_q   <= 1'b0;
          rsp_rdata_q <= mem.rdata;
          rsp_err_q   <= rsp_err_q | mem.err;
          case (op_q)
            OpRmw: begin
              if (mem.err) begin
                state_q     <= StRsp;
                rsp_valid_q <= 1'b1;
              end else begin
                state_q     <= StWr;
                mem_ena_q   <= 1'b1;
                mem_wena_q  <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= DW'(rmw_merge(MaxDw'(mem.rdata), MaxDw'(wdata_q),
                                             MaxDw'(mask_q)));
              end
            end
`ifdef REGF_MEM_MASTER_POLL_EN
            OpPoll: begin
              if (mem.err || poll_hit) begin
                state_q     <= StRsp;
                rsp_valid_q <= 1'b1;
              end else if (poll_cnt_q == CntW'(POLL_MAX)) begin
                state_q       <= StRsp;
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b1;
              end else begin
                state_q    <= StPgap;
                poll_cnt_q <= poll_cnt_q + 1'b1;
              end
            end
`endif
            default: begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
            end
          endcase
        end

        // Idle gap between poll reads keeps mem_ena_o from staying high.
        StPgap: begin
          state_q     <= StRd;
          mem_ena_q   <= 1'b1;
          mem_wena_q  <= 1'b0;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= '0;
        end

        StWr: begin
          state_q     <= StRsp;
          mem_ena_q   <= 1'b0;
          mem_wena_q  <= 1'b0;
          rsp_err_q   <= rsp_err_q | mem.err;
          rsp_valid_q <= 1'b1;
        end

        StRsp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  assign mem.ena   = mem_ena_q;
  assign mem.wena  = mem_wena_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;

endmodule

// File: tb/tb_regf_mem_master.sv
// Directed bench for regf_mem_master against a small regf responder (addr 0 valid, others err).
module tb_regf_mem_master;
  import regf_mem_master_pkg::*;

  localparam int unsigned AW      = 13;
  localparam int unsigned DW      = 32;
  localparam int unsigned PollMax = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;

  always #5 clk = ~clk;

  regf_mem_master_if #(.AW(AW), .DW(DW)) mif ();

  regf_mem_master #(.AW(AW), .DW(DW), .POLL_MAX(PollMax)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_mask_i    (cmd_mask),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .mem           (mif),
    .busy_o        (busy)
  );

  // Responder: one word at addr 0; bit0 of read data forced once rd_cnt reaches set_at.
  logic [DW-1:0] mem_val = '0;
  logic [DW-1:0] last_wdata = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            rd_wdata_bad = 0;
  int            set_at = 1 << 30;

  assign mif.rdata = (mif.addr == '0) ? (mem_val | ((rd_cnt >= set_at) ? 32'h1 : 32'h0)) : '0;
  assign mif.err   = mif.ena && (mif.addr != '0);

  always @(posedge clk) begin
    if (mif.ena) begin
      if (mif.wena) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= mif.wdata;
        if (mif.addr == '0) mem_val <= mif.wdata;
      end else begin
        rd_cnt <= rd_cnt + 1;
        if (mif.wdata != '0) rd_wdata_bad <= rd_wdata_bad + 1;
      end
    end
  end

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int            lat;
  logic [DW-1:0] r_rd;
  logic          r_err;
  logic          r_tmo;
  int            r0;
  int            w0;

  // Issue one command and wait (bounded) for rsp_valid; returns at a negedge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] mk);
    @(negedge clk);
    chk_eq("cmd_ready before accept", cmd_ready, 1'b1);
    r0 = rd_cnt;
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_mask  = mk;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    r_rd  = rsp_rdata;
    r_err = rsp_err;
    r_tmo = rsp_timeout;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish earlier");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst cmd_ready", cmd_ready, 1'b1);
    chk_eq("rst busy", busy, 1'b0);
    chk_eq("rst rsp_valid", rsp_valid, 1'b0);
    chk_eq("rst rsp_err", rsp_err, 1'b0);
    chk_eq("rst rsp_rdata", rsp_rdata, 32'h0);
    chk_eq("rst mem_ena", mif.ena, 1'b0);
    chk_eq("rst mem_wena", mif.wena, 1'b0);
    chk_eq("rst mem_addr", mif.addr, 13'h0);
    chk_eq("rst mem_wdata", mif.wdata, 32'h0);
    rst_n = 1'b1;

    // WRITE 0x10 then READ it back
    issue(2'd1, 13'h0, 32'h10, 32'h0);
    chk_eq("wr10 lat", lat, 2);
    chk_eq("wr10 err", r_err, 1'b0);
    chk_eq("wr10 rdata", r_rd, 32'h0);
    chk_eq("wr10 writes", wr_cnt - w0, 1);
    chk_eq("wr10 reads", rd_cnt - r0, 0);
    chk_eq("wr10 bus wdata", last_wdata, 32'h10);
    ack();

    issue(2'd0, 13'h0, 32'h0, 32'h0);
    chk_eq("rd lat", lat, 2);
    chk_eq("rd rdata", r_rd, 32'h10);
    chk_eq("rd err", r_err, 1'b0);
    chk_eq("rd reads", rd_cnt - r0, 1);
    chk_eq("rd writes", wr_cnt - w0, 0);
    ack();

    issue(2'd1, 13'h0, 32'h2, 32'h0);
    chk_eq("wr2 lat", lat, 2);
    chk_eq("wr2 bus wdata", last_wdata, 32'h2);
    chk_eq("wr2 err", r_err, 1'b0);
    ack();

    // RMW: (F0 & ~03) | (0F & 03) = F3, response carries F0
    issue(2'd1, 13'h0, 32'hF0, 32'h0);
    ack();
    issue(2'd2, 13'h0, 32'h0F, 32'h03);
    chk_eq("rmw lat", lat, 3);
    chk_eq("rmw rdata", r_rd, 32'hF0);
    chk_eq("rmw err", r_err, 1'b0);
    chk_eq("rmw bus wdata", last_wdata, 32'hF3);
    chk_eq("rmw reads", rd_cnt - r0, 1);
    chk_eq("rmw writes", wr_cnt - w0, 1);
    ack();

    // Decode errors
    issue(2'd0, 13'h4, 32'h0, 32'h0);
    chk_eq("rd err lat", lat, 2);
    chk_eq("rd err flag", r_err, 1'b1);
    ack();

    issue(2'd2, 13'h4, 32'hFF, 32'hFF);
    chk_eq("rmw err lat", lat, 2);
    chk_eq("rmw err flag", r_err, 1'b1);
    chk_eq("rmw err reads", rd_cnt - r0, 1);
    chk_eq("rmw err writes", wr_cnt - w0, 0);
    ack();

    // err clears on next accept
    issue(2'd0, 13'h0, 32'h0, 32'h0);
    chk_eq("err cleared", r_err, 1'b0);
    chk_eq("rd after rmw", r_rd, 32'hF3);
    ack();

    issue(2'd1, 13'h0, 32'h0, 32'h0);
    ack();
`ifdef REGF_MEM_MASTER_POLL_EN
    set_at = rd_cnt + 2;
    issue(2'd3, 13'h0, 32'h1, 32'h1);
    chk_eq("poll hit lat", lat, 6);
    chk_eq("poll hit reads", rd_cnt - r0, 3);
    chk_eq("poll hit rdata", r_rd, 32'h1);
    chk_eq("poll hit timeout", r_tmo, 1'b0);
    chk_eq("poll hit err", r_err, 1'b0);
    ack();
    set_at = 1 << 30;

    issue(2'd3, 13'h0, 32'h1, 32'h1);
    chk_eq("poll tmo lat", lat, 10);
    chk_eq("poll tmo reads", rd_cnt - r0, 5);
    chk_eq("poll tmo flag", r_tmo, 1'b1);
    chk_eq("poll tmo rdata", r_rd, 32'h0);
    chk_eq("poll tmo err", r_err, 1'b0);
    ack();

    issue(2'd3, 13'h4, 32'h1, 32'h1);
    chk_eq("poll err lat", lat, 2);
    chk_eq("poll err flag", r_err, 1'b1);
    chk_eq("poll err reads", rd_cnt - r0, 1);
    ack();
`else
    issue(2'd3, 13'h0, 32'h1, 32'h1);
    chk_eq("poll off lat", lat, 1);
    chk_eq("poll off err", r_err, 1'b1);
    chk_eq("poll off timeout", r_tmo, 1'b0);
    chk_eq("poll off reads", rd_cnt - r0, 0);
    chk_eq("poll off writes", wr_cnt - w0, 0);
    ack();
`endif

    // Response backpressure
    issue(2'd1, 13'h0, 32'h5A, 32'h0);
    ack();
    issue(2'd0, 13'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp rsp_valid", rsp_valid, 1'b1);
      chk_eq("bp rdata", rsp_rdata, 32'h5A);
      chk_eq("bp cmd_ready", cmd_ready, 1'b0);
      chk_eq("bp busy", busy, 1'b1);
      chk_eq("bp mem_ena", mif.ena, 1'b0);
      @(negedge clk);
    end
    ack();
    @(negedge clk);
    chk_eq("bp released valid", rsp_valid, 1'b0);
    chk_eq("bp released ready", cmd_ready, 1'b1);

    // Async reset while the read access is on the bus
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_addr  = 13'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk_eq("mid rd ena", mif.ena, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("arst ena", mif.ena, 1'b0);
    chk_eq("arst addr", mif.addr, 13'h0);
    chk_eq("arst rsp_valid", rsp_valid, 1'b0);
    chk_eq("arst rsp_rdata", rsp_rdata, 32'h0);
    chk_eq("arst busy", busy, 1'b0);
    chk_eq("arst cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("no stale rsp", rsp_valid, 1'b0);

    chk_eq("read wdata zero", rd_wdata_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
